bsg_cat_map_ctrl: RTL and testbench

- Control and framing stage that sits directly upstream and downstream of the Arnold-cat cell array.
- Accepts a plaintext image as a stream of fixed-width words, plus a per-frame iteration key.
- Loads the frame into the array with a one-cycle update pulse, then enables the array for exactly key cycles.
- Captures the permuted frame and streams it out as words under ready/valid backpressure.

---
 rtl/bsg_cat_map_ctrl.sv | 97 +++++++++
 tb/tb_bsg_cat_map_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bsg_cat_map_ctrl.sv
// Framing/control around the Arnold-cat cell array: load words, pulse update,
// run the array for key cycles, capture the result and stream it back out.
module bsg_cat_map_ctrl #(
  parameter int board_width_p = 8,
  parameter int word_width_p  = 8,
  parameter int iter_width_p  = 16,
  localparam int num_cells_lp = board_width_p * board_width_p,
  localparam int num_words_lp = num_cells_lp / word_width_p,
  localparam int idx_w_lp     = (num_words_lp > 1) ? $clog2(num_words_lp) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [word_width_p-1:0] in_data_i,
  input  logic                    in_v_i,
  input  logic [iter_width_p-1:0] in_key_i,
  output logic                    in_ready_o,
  output logic [num_cells_lp-1:0] ca_data_o,
  output logic                    ca_update_o,
  output logic                    ca_en_o,
  input  logic [num_cells_lp-1:0] ca_data_i,
  output logic [word_width_p-1:0] out_data_o,
  output logic                    out_v_o,
  input  logic                    out_ready_i,
  output logic                    busy_o
);

  localparam logic [2:0] S_LOAD    = 3'd0;
  localparam logic [2:0] S_UPDATE  = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_UNLOAD  = 3'd4;

  logic [2:0]              r_state;
  logic [idx_w_lp-1:0]     r_idx;
  logic [iter_width_p-1:0] r_iter;
  logic [iter_width_p-1:0] r_cnt;
  logic [num_cells_lp-1:0] r_frame;
  logic                    w_last;

  assign w_last = (r_idx == idx_w_lp'(num_words_lp - 1));

  // Every output is a decode of state or a register, so neither handshake
  // input has a combinational path to an output.
  assign in_ready_o  = (r_state == S_LOAD);
  assign ca_update_o = (r_state == S_UPDATE);
  assign ca_en_o     = (r_state == S_RUN);
  assign out_v_o     = (r_state == S_UNLOAD);
  assign busy_o      = (r_state != S_LOAD);
  assign ca_data_o   = r_frame;
  assign out_data_o  = r_frame[r_idx*word_width_p +: word_width_p];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_LOAD;
      r_idx   <= '0;
      r_iter  <= '0;
      r_cnt   <= '0;
      r_frame <= '0;
    end else begin
      case (r_state)
        S_LOAD: if (in_v_i) begin
          r_frame[r_idx*word_width_p +: word_width_p] <= in_data_i;
          if (r_idx == '0) r_iter <= in_key_i;
          if (w_last) begin
            r_idx   <= '0;
            r_state <= S_UPDATE;
          end else begin
            r_idx <= r_idx + idx_w_lp'(1);
          end
        end
        S_UPDATE: begin
          r_cnt   <= r_iter;
          r_state <= (r_iter != '0) ? S_RUN : S_CAPTURE;
        end
        // r_cnt is never 0 here: a zero key bypasses RUN entirely
        S_RUN: begin
          r_cnt <= r_cnt - iter_width_p'(1);
          if (r_cnt == iter_width_p'(1)) r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_frame <= ca_data_i;
          r_state <= S_UNLOAD;
        end
        S_UNLOAD: if (out_ready_i) begin
          if (w_last) begin
            r_idx   <= '0;
            r_state <= S_LOAD;
          end else begin
            r_idx <= r_idx + idx_w_lp'(1);
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_cat_map_ctrl.sv
// Bench for bsg_cat_map_ctrl on a 4x4 board with a behavioural cat-map array
// attached; expected frames use the map's period of 3 at width 4.
module tb_bsg_cat_map_ctrl;
  localparam int BW = 4;
  localparam int NC = BW * BW;
  localparam int WW = 4;
  localparam int NW = NC / WW;
  localparam int IW = 16;

  logic          clk = 0;
  logic          reset_n_i;
  logic [WW-1:0] in_data_i;
  logic          in_v_i;
  logic [IW-1:0] in_key_i;
  logic          in_ready_o;
  logic [NC-1:0] ca_data_o;
  logic          ca_update_o;
  logic          ca_en_o;
  logic [NC-1:0] arr = '0;
  logic [WW-1:0] out_data_o;
  logic          out_v_o;
  logic          out_ready_i;
  logic          busy_o;

  int n_chk = 0, n_pass = 0, cyc = 0;
  int en_cnt = 0, upd_cnt = 0, both_cnt = 0;

  bsg_cat_map_ctrl #(.board_width_p(BW), .word_width_p(WW), .iter_width_p(IW)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .in_data_i(in_data_i), .in_v_i(in_v_i), .in_key_i(in_key_i), .in_ready_o(in_ready_o),
    .ca_data_o(ca_data_o), .ca_update_o(ca_update_o), .ca_en_o(ca_en_o), .ca_data_i(arr),
    .out_data_o(out_data_o), .out_v_o(out_v_o), .out_ready_i(out_ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // new(x,y) = old((2x+y) mod N, (x+y) mod N), cell index y*N+x
  function automatic logic [NC-1:0] cat_step(input logic [NC-1:0] s);
    logic [NC-1:0] r;
    r = '0;
    for (int y = 0; y < BW; y++)
      for (int x = 0; x < BW; x++)
        r[y*BW+x] = s[((x+y)%BW)*BW + (2*x+y)%BW];
    return r;
  endfunction

  // Behavioural cell array driven by the controller
  always @(posedge clk) begin
    if (ca_update_o)  arr <= ca_data_o;
    else if (ca_en_o) arr <= cat_step(arr);
  end

  always @(negedge clk) begin
    if (ca_en_o) en_cnt++;
    if (ca_update_o) upd_cnt++;
    if (ca_en_o && ca_update_o) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send_frame(input logic [NC-1:0] frame, input int key, input int gap,
                            input bit key_chg, input int up0, output int hs_cyc);
    for (int w = 0; w < NW; w++) begin
      repeat (gap) begin
        in_v_i = 0; in_data_i = WW'($urandom); in_key_i = IW'($urandom);
        @(posedge clk); #1;
      end
      if (w == NW-1) chk("upd_before_last_word", 32'(upd_cnt - up0), 0);
      chk("in_ready_load", {31'd0, in_ready_o}, 1);
      in_v_i = 1; in_data_i = frame[w*WW +: WW];
      in_key_i = (w == 0 || !key_chg) ? IW'(key) : IW'($urandom);
      hs_cyc = cyc;
      @(posedge clk); #1;
    end
    in_v_i = 0;
  endtask

  // bp: 0 always ready, 1 toggling, 2 random
  task automatic run_frame(input logic [NC-1:0] frame, input int key, input int gap,
                           input int bp, input bit key_chg, input bit noise);
    int hs_cyc, first_cyc, n_rx, hold_bad, rdy_bad, t, en0, up0, both0;
    logic [NC-1:0] exp;
    logic [WW-1:0] held;
    bit stalled;
    en0 = en_cnt; up0 = upd_cnt; both0 = both_cnt;
    first_cyc = -1; n_rx = 0; hold_bad = 0; rdy_bad = 0; t = 0; stalled = 0; held = '0;
    send_frame(frame, key, gap, key_chg, up0, hs_cyc);
    exp = frame;
    repeat (key % 3) exp = cat_step(exp);
    while (n_rx < NW && t < 3000) begin
      out_ready_i = (bp == 0) ? 1'b1 : (bp == 1) ? 1'(t % 2) : 1'($urandom);
      if (noise) begin in_v_i = 1'($urandom); in_data_i = WW'($urandom); end
      if (in_ready_o || !busy_o) rdy_bad++;
      if (stalled && (!out_v_o || out_data_o !== held)) hold_bad++;
      if (out_v_o) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (out_ready_i) begin
          chk($sformatf("word%0d", n_rx), 32'(out_data_o), 32'(exp[n_rx*WW +: WW]));
          n_rx++; stalled = 0;
        end else begin
          stalled = 1; held = out_data_o;
        end
      end
      @(posedge clk); #1; t++;
    end
    in_v_i = 0; out_ready_i = 0;
    chk("words_received", 32'(n_rx), NW);
    chk("latency", 32'(first_cyc - hs_cyc), 32'(key + 3));
    chk("en_cycles", 32'(en_cnt - en0), 32'(key));
    chk("upd_pulses", 32'(upd_cnt - up0), 1);
    chk("upd_en_overlap", 32'(both_cnt - both0), 0);
    chk("in_ready_while_busy", 32'(rdy_bad), 0);
    chk("stall_hold", 32'(hold_bad), 0);
    chk("back_to_load", {30'd0, in_ready_o, busy_o}, 32'b10);
  endtask

  initial begin
    int hs;
    reset_n_i = 0; in_v_i = 0; in_data_i = '0; in_key_i = '0; out_ready_i = 0;
    #12;
    chk("rst_flags", {27'd0, in_ready_o, out_v_o, ca_update_o, ca_en_o, busy_o}, 32'b10000);
    chk("rst_ca_data", 32'(ca_data_o), 0);
    @(posedge clk); #1 reset_n_i = 1;

    run_frame(16'h0002, 1, 0, 0, 0, 0);
    run_frame(16'hB3C5, 3, 0, 0, 0, 0);
    run_frame(16'hA5A5, 0, 0, 0, 0, 0);
    run_frame(16'hB3C5, 3, 0, 1, 0, 1);
    run_frame(16'($urandom), 2, 2, 0, 1, 0);

    // Asynchronous reset in the middle of a long run
    send_frame(16'h1234, 100, 0, 0, upd_cnt, hs);
    repeat (10) @(posedge clk);
    #2;
    chk("running_before_rst", {31'd0, ca_en_o}, 1);
    #1 reset_n_i = 0;
    #1;
    chk("midrun_rst_flags", {27'd0, in_ready_o, out_v_o, ca_update_o, ca_en_o, busy_o}, 32'b10000);
    chk("midrun_rst_ca_data", 32'(ca_data_o), 0);
    @(posedge clk); #1 reset_n_i = 1;
    run_frame(16'h0002, 1, 0, 0, 0, 0);

    for (int i = 0; i < 8; i++)
      run_frame(16'($urandom), $urandom_range(0, 20), $urandom_range(0, 2), 2, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
